// File: rtl/mips_axi_mem_slave.sv
// mips_axi_mem_slave: word-addressed on-chip memory serving independent AXI write and read bursts
module mips_axi_mem_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  err
);
  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  w_state_e w_state_q, w_state_d;
  logic [3:0] w_id_q, w_len_q, w_cnt_q;
  logic [INDEX_WIDTH-1:0] w_idx_q;
  logic err_q;
  r_state_e r_state_q, r_state_d;
  logic [3:0] r_id_q, r_len_q, r_cnt_q, r_lat_q;
  logic [INDEX_WIDTH-1:0] r_idx_q, ar_idx, load_idx;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic aw_hs, w_beat, w_final, ar_hs, r_hs, r_last, r_wait_done, r_load;
  logic addr_unused;
  // Address bits outside the word index are deliberately ignored so the array aliases.
  assign addr_unused = ^{AWADDR[ADDR_WIDTH-1:INDEX_WIDTH+2], AWADDR[1:0],
                         ARADDR[ADDR_WIDTH-1:INDEX_WIDTH+2], ARADDR[1:0]};
  assign aw_hs       = AWVALID & AWREADY;
  assign w_beat      = WVALID & WREADY;
  assign w_final     = w_cnt_q == w_len_q;
  assign ar_hs       = ARVALID & ARREADY;
  assign r_hs        = RVALID & RREADY;
  assign r_last      = r_cnt_q == r_len_q;
  assign ar_idx      = ARADDR[INDEX_WIDTH+1:2];
  assign r_wait_done = (r_state_q == R_WAIT) && (r_lat_q == 4'd1);
  // A beat is fetched into RDATA when it first becomes visible and after each accepted beat.
  assign r_load      = (ar_hs && READ_LATENCY == 1) || r_wait_done || r_hs;
  assign load_idx    = (r_state_q == R_IDLE) ? ar_idx : r_idx_q;

  // Write FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) w_state_q <= W_IDLE;
    else w_state_q <= w_state_d;

  // Write FSM next state: the burst always ends on the beat count, regardless of WLAST
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (AWVALID) w_state_d = W_DATA;
      W_DATA:  if (WVALID && w_final) w_state_d = W_RESP;
      W_RESP:  if (BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel handshake outputs decoded from state
  always_comb begin
    AWREADY = w_state_q == W_IDLE;
    WREADY  = w_state_q == W_DATA;
    BVALID  = w_state_q == W_RESP;
    BID     = w_id_q;
    err     = err_q;
  end

  // Write burst bookkeeping and sticky protocol-error detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_id_q  <= '0;
      w_len_q <= '0;
      w_cnt_q <= '0;
      w_idx_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id_q  <= AWID;
        w_len_q <= AWLEN;
        w_cnt_q <= '0;
        w_idx_q <= AWADDR[INDEX_WIDTH+1:2];
      end
      if (w_beat) begin
        w_cnt_q <= w_cnt_q + 4'd1;
        w_idx_q <= w_idx_q + 1'b1;
        if ((WLAST != w_final) || (WID != w_id_q)) err_q <= 1'b1;
      end
    end

  // Array write port; contents survive reset
  always_ff @(posedge clk)
    if (w_beat) mem_q[w_idx_q] <= WDATA;

  // Read FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state_q <= R_IDLE;
    else r_state_q <= r_state_d;

  // Read FSM next state: a latency of one skips the wait state
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ARVALID) r_state_d = (READ_LATENCY == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (r_lat_q == 4'd1) r_state_d = R_DATA;
      R_DATA:  if (RREADY && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel outputs decoded from state and the registered beat
  always_comb begin
    ARREADY = r_state_q == R_IDLE;
    RVALID  = r_state_q == R_DATA;
    RLAST   = (r_state_q == R_DATA) && r_last;
    RID     = r_id_q;
    RDATA   = rdata_q;
  end

  // Read burst bookkeeping; RDATA samples the array before a same-edge write lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_id_q  <= '0;
      r_len_q <= '0;
      r_cnt_q <= '0;
      r_lat_q <= '0;
      r_idx_q <= '0;
      rdata_q <= '0;
    end else begin
      if (ar_hs) begin
        r_id_q  <= ARID;
        r_len_q <= ARLEN;
        r_cnt_q <= '0;
        r_lat_q <= LAT_INIT;
      end
      if (r_state_q == R_WAIT) r_lat_q <= r_lat_q - 4'd1;
      if (r_hs) r_cnt_q <= r_cnt_q + 4'd1;
      if (r_load) begin
        rdata_q <= mem_q[load_idx];
        r_idx_q <= load_idx + 1'b1;
      end else if (ar_hs) r_idx_q <= ar_idx;
    end
endmodule

// File: doc/mips_axi_mem_slave.md
# mips_axi_mem_slave

Simulation/FPGA memory model that sits directly downstream of the MIPS core's external AXI ports. It consumes the core's AW/W/B and AR/R channels, which the memory arbiter multiplexes from the I-cache, D-cache and stream buffer, and services them from a word-addressed on-chip array. The read and write channels run independently, each controlled by its own FSM. Burst lengths follow the core's 4-bit AxLEN encoding (beats = LEN+1).

## Interface
Parameters:
- `ADDR_WIDTH`, `` `ADDR_WIDTH ``: byte-address width of AWADDR/ARADDR.
- `DATA_WIDTH`, `` `DATA_WIDTH `` (32): beat width.
- `INDEX_WIDTH`, 12: log2 of array depth in words (4096 words).
- `READ_LATENCY`, 2: cycles from AR handshake to first RVALID; legal range 1..15.

Ports (reset is asynchronous and active-low; one clock):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `AWVALID`  in  1 / `AWREADY`  out  1 / `AWID`  in  4 / `AWLEN`  in  4 / `AWADDR`  in  ADDR_WIDTH  write address channel
- `WVALID`  in  1 / `WREADY`  out  1 / `WLAST`  in  1 / `WID`  in  4 / `WDATA`  in  DATA_WIDTH  write data channel
- `BVALID`  out  1 / `BREADY`  in  1 / `BID`  out  4  write response channel
- `ARVALID`  in  1 / `ARREADY`  out  1 / `ARID`  in  4 / `ARLEN`  in  4 / `ARADDR`  in  ADDR_WIDTH  read address channel
- `RVALID`  out  1 / `RREADY`  in  1 / `RLAST`  out  1 / `RID`  out  4 / `RDATA`  out  DATA_WIDTH  read data channel
- `err`  out  1  sticky protocol-error flag

## Operation
- Word index = ADDR[INDEX_WIDTH+1:2]. ADDR[1:0] is ignored. Upper bits are ignored, so the array aliases.
- Burst beat k targets index (base+k) mod 2^INDEX_WIDTH, wrapping at the top of the array.
- Array contents are not reset.
- Write FSM: `W_IDLE -> W_DATA -> W_RESP -> W_IDLE`.
  - W_IDLE: AWREADY=1. On AWVALID, latch AWID, AWLEN, base index; clear beat counter; go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes WDATA to the current index and increments the counter. The beat with counter==LEN is final; go to W_RESP.
  - Protocol errors set `err` (sticky until reset); the burst still ends on the beat count:
    - WLAST=1 on a non-final beat, or WLAST=0 on the final beat.
    - WID differs from the latched AWID on any beat.
  - W_RESP: BVALID=1 and BID = latched AWID. Hold until BREADY; on handshake go to W_IDLE.
- Read FSM: `R_IDLE -> R_WAIT -> R_DATA -> R_IDLE`.
  - R_IDLE: ARREADY=1. On ARVALID, latch ARID, ARLEN, base index; load latency counter with READ_LATENCY-1.
    - If READ_LATENCY==1, go straight to R_DATA, loading beat 0 into RDATA.
  - R_WAIT: decrement the counter. When it reaches 0, load beat 0 into the RDATA register and go to R_DATA.
  - R_DATA: RVALID=1, RID = latched ARID, RLAST = (counter==LEN).
    - On RREADY, load the next beat into RDATA the same edge.
    - On RREADY with RLAST, go to R_IDLE.
    - RDATA, RLAST and RID stay stable while RVALID=1 and RREADY=0.
- Read/write collision: when a W beat and an RDATA load hit the same index on the same edge, RDATA gets the old value (read-before-write). A beat already loaded into RDATA is never updated by a later write.
- Channels are fully concurrent; no ordering is enforced between reads and writes.

## Timing
- Reset values (both FSMs reset to IDLE):
  - AWREADY=1, ARREADY=1.
  - WREADY=0, BVALID=0, RVALID=0, RLAST=0, err=0.
  - BID=0, RID=0, RDATA=0.
- Write timing:
  - AW handshake in cycle N: WREADY=1 from N+1. AWREADY=0 from N+1 until the cycle after the B handshake.
  - Final W handshake in cycle M: BVALID=1 in M+1; WREADY=0 in M+1.
  - B handshake in cycle P: AWREADY=1 in P+1.
  - Minimum write throughput is LEN+3 cycles per burst.
- Read timing:
  - AR handshake in cycle N: first RVALID in N+READ_LATENCY; ARREADY=0 from N+1.
  - One beat per cycle while RREADY=1.
  - Last R handshake in cycle P: RVALID=0 and ARREADY=1 in P+1.
- Reset asserted mid-burst: both FSMs go to IDLE immediately (asynchronous). Partially written data stays in the array and no B response is issued.

## Test plan
- Single write then read:
  - Stimulus: AW id=3, len=0, addr=0x40; W 0xDEADBEEF with WLAST.
  - Required response: BVALID one cycle after the W beat with BID=3. Then AR id=5, len=0, addr=0x40 returns RDATA=0xDEADBEEF, RID=5, RLAST=1, first RVALID exactly 2 cycles after the AR handshake.
- 4-beat burst with backpressure:
  - Stimulus: write 0x1..0x4 at 0x100 with len=3. Read them back with RREADY toggled 1,0,0,1,1,0,1.
  - Required response: beats come out in order 0x1..0x4; RDATA is held during stalls; RLAST only on 0x4.
- Wrap-around:
  - Stimulus: len=1 write at word 4095 (addr 0x3FFC) with 0xA, 0xB.
  - Required response: reading addr 0x0 returns 0xB.
- Protocol error:
  - Stimulus: len=1 write with WLAST=1 on beat 0.
  - Required response: err=1 from the next cycle; the burst still takes 2 beats; BVALID follows; err stays 1.
- Concurrency and collision:
  - Stimulus: an AR and an AW with the same address accepted in the same cycle, where the write beat lands on the same edge as the RDATA load.
  - Required response: the read returns the pre-write value; a later read returns the new value.
- Reset mid-read:
  - Stimulus: assert rst_n=0 during R_DATA.
  - Required response: RVALID=0 and ARREADY=1 immediately (asynchronously), with all outputs at their reset values.
